// File: rtl/accum_alu_pkg.sv
// ============================================================================
// Module      : accum_alu_pkg
// Description : Opcode and FSM state encodings plus default datapath width
//               shared by the accumulator ALU, its interface and the bench.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package accum_alu_pkg;

    localparam int c_default_width = 8;

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_LOAD = 3'b001,
        OP_ADD  = 3'b010,
        OP_SUB  = 3'b011,
        OP_XNOR = 3'b100,
        OP_AND  = 3'b101,
        OP_MUL  = 3'b110,
        OP_CLR  = 3'b111
    } op_t;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/accum_alu_if.sv
// ============================================================================
// Module      : accum_alu_if
// Description : Command handshake and result bus of the accumulator ALU.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface accum_alu_if
    import accum_alu_pkg::*;
#(
    parameter int WIDTH = c_default_width
) ();

    logic             in_valid;
    logic             in_ready;
    op_t              op;
    logic [WIDTH-1:0] operand;
    logic [WIDTH-1:0] acc;
    logic             done;
    logic             busy;
    logic             carry;
    logic             zero;
    logic             err;

    modport master (
        output in_valid, op, operand,
        input  in_ready, acc, done, busy, carry, zero, err
    );

    modport slave (
        input  in_valid, op, operand,
        output in_ready, acc, done, busy, carry, zero, err
    );

endinterface

`default_nettype wire

// File: rtl/accum_alu_mul.sv
// ============================================================================
// Module      : accum_alu_mul
// Description : Unsigned shift-add multiplier, one partial product per cycle.
//               'product' is the value after the current step; 'last' flags
//               the step that completes the WIDTH-th iteration.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module accum_alu_mul
    import accum_alu_pkg::*;
#(
    parameter int WIDTH = c_default_width
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               start,
    input  wire logic [WIDTH-1:0]   multiplicand,
    input  wire logic [WIDTH-1:0]   multiplier,
    output logic      [2*WIDTH-1:0] product,
    output logic                    last
);

    localparam int CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] r_prod;
    logic [WIDTH-1:0]   r_mcand;
    logic [CW-1:0]      r_count;
    logic               r_run;
    logic [WIDTH:0]     w_upper;
    logic [2*WIDTH-1:0] w_step;

    // Upper half accumulates the multiplicand when the current multiplier LSB is set,
    // then the whole register shifts right, retiring one multiplier bit.
    always_comb begin
        w_upper = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_mcand} : '0);
        w_step  = {w_upper, r_prod[WIDTH-1:1]};
    end

    assign product = w_step;
    assign last    = r_run && (r_count == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prod  <= '0;
            r_mcand <= '0;
            r_count <= '0;
            r_run   <= 1'b0;
        end else if (start) begin
            r_prod  <= {{WIDTH{1'b0}}, multiplier};
            r_mcand <= multiplicand;
            r_count <= '0;
            r_run   <= 1'b1;
        end else if (r_run) begin
            r_prod <= w_step;
            if (last) begin
                r_count <= '0;
                r_run   <= 1'b0;
            end else begin
                r_count <= r_count + CW'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/accum_alu.sv
// ============================================================================
// Module      : accum_alu
// Description : Accumulator ALU with single-cycle ops and an optional
//               multi-cycle MUL enabled by macro ACCUM_ALU_MUL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module accum_alu
    import accum_alu_pkg::*;
#(
    parameter int WIDTH = c_default_width
) (
    input  wire logic  clk,
    input  wire logic  RESET,
    accum_alu_if.slave bus
);

    state_t           r_state;
    logic [WIDTH-1:0] r_acc;
    logic             r_carry;
    logic             r_zero;
    logic             r_err;
    logic             r_done;

    logic             w_accept;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_res;
    logic             w_res_carry;
    logic             w_write;

    assign w_accept = bus.in_valid && (r_state == S_IDLE);
    assign w_sum    = {1'b0, r_acc} + {1'b0, bus.operand};
    assign w_diff   = {1'b0, r_acc} - {1'b0, bus.operand};

    always_comb begin
        w_res       = r_acc;
        w_res_carry = r_carry;
        w_write     = 1'b0;
        case (bus.op)
            OP_LOAD: begin w_res = bus.operand;          w_write = 1'b1; end
            OP_ADD:  begin w_res = w_sum[WIDTH-1:0];  w_res_carry = w_sum[WIDTH];  w_write = 1'b1; end
            OP_SUB:  begin w_res = w_diff[WIDTH-1:0]; w_res_carry = w_diff[WIDTH]; w_write = 1'b1; end
            OP_XNOR: begin w_res = ~(r_acc ^ bus.operand); w_res_carry = 1'b0; w_write = 1'b1; end
            OP_AND:  begin w_res = r_acc & bus.operand;    w_res_carry = 1'b0; w_write = 1'b1; end
            OP_CLR:  begin w_res = '0;                     w_res_carry = 1'b0; w_write = 1'b1; end
            default: ;
        endcase
    end

`ifdef ACCUM_ALU_MUL_EN
    logic               w_mul_start;
    logic [2*WIDTH-1:0] w_product;
    logic               w_mul_last;

    assign w_mul_start = w_accept && (bus.op == OP_MUL);

    accum_alu_mul #(
        .WIDTH        (WIDTH)
    ) u_mul (
        .clk          (clk),
        .rst          (RESET),
        .start        (w_mul_start),
        .multiplicand (r_acc),
        .multiplier   (bus.operand),
        .product      (w_product),
        .last         (w_mul_last)
    );
`endif

    always_ff @(posedge clk) begin
        if (RESET) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_zero  <= 1'b1;
            r_err   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_err  <= 1'b0;
                        r_done <= 1'b1;
                        if (bus.op == OP_MUL) begin
`ifdef ACCUM_ALU_MUL_EN
                            r_done  <= 1'b0;
                            r_state <= S_MUL;
`else
                            // No multiplier in this build: retire MUL as an illegal op.
                            r_err <= 1'b1;
`endif
                        end else if (w_write) begin
                            r_acc   <= w_res;
                            r_carry <= w_res_carry;
                            r_zero  <= (w_res == '0);
                        end
                    end
                end
                S_MUL: begin
`ifdef ACCUM_ALU_MUL_EN
                    if (w_mul_last) begin
                        r_acc   <= w_product[WIDTH-1:0];
                        r_carry <= |w_product[2*WIDTH-1:WIDTH];
                        r_zero  <= (w_product[WIDTH-1:0] == '0);
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
`else
                    r_state <= S_IDLE;
`endif
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready = (r_state == S_IDLE);
    assign bus.busy     = (r_state == S_MUL);
    assign bus.acc      = r_acc;
    assign bus.carry    = r_carry;
    assign bus.zero     = r_zero;
    assign bus.err      = r_err;
    assign bus.done     = r_done;

endmodule

`default_nettype wire

// File: tb/tb_accum_alu.sv
// ============================================================================
// Module      : tb_accum_alu
// Description : Directed self-checking bench for accum_alu (WIDTH=8); an
//               arithmetic reference model is compared every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_accum_alu;
    import accum_alu_pkg::*;

    localparam int     WIDTH = 8;
    localparam longint M     = longint'(1) << WIDTH;
    localparam longint MASK  = M - 1;

    logic clk = 1'b0;
    logic RESET;
    always #5 clk = ~clk;

    accum_alu_if #(.WIDTH(WIDTH)) bus ();

    accum_alu #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .RESET (RESET),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the full-precision result.
    function automatic longint f_raw(op_t o, longint a, longint b);
        case (o)
            OP_LOAD: return b;
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_XNOR: return ~(a ^ b);
            OP_AND:  return a & b;
            OP_CLR:  return 0;
            OP_MUL:  return a * b;
            default: return a;
        endcase
    endfunction

    function automatic logic f_carry(op_t o, longint a, longint b, logic keep);
        case (o)
            OP_ADD:  return (a + b) >= M;
            OP_SUB:  return b > a;
            OP_MUL:  return (a * b) >= M;
            OP_XNOR, OP_AND, OP_CLR: return 1'b0;
            default: return keep;
        endcase
    endfunction

    logic [WIDTH-1:0] m_acc, m_pacc;
    logic             m_carry, m_zero, m_err, m_done, m_pcarry;
    int               m_left;
    logic             m_live = 1'b0;

    always @(posedge clk) begin
        if (RESET) begin
            m_acc <= '0; m_carry <= 1'b0; m_zero <= 1'b1; m_err <= 1'b0;
            m_done <= 1'b0; m_left <= 0; m_live <= 1'b1;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            m_done <= (m_left == 1);
            if (m_left == 1) begin
                m_acc   <= m_pacc;
                m_carry <= m_pcarry;
                m_zero  <= (m_pacc == '0);
            end
        end else begin
            m_done <= 1'b0;
            if (bus.in_valid) begin
                if (bus.op == OP_MUL) begin
`ifdef ACCUM_ALU_MUL_EN
                    m_left   <= WIDTH;
                    m_pacc   <= WIDTH'(f_raw(OP_MUL, m_acc, bus.operand) & MASK);
                    m_pcarry <= f_carry(OP_MUL, m_acc, bus.operand, m_carry);
                    m_err    <= 1'b0;
`else
                    m_done <= 1'b1;
                    m_err  <= 1'b1;
`endif
                end else begin
                    m_done <= 1'b1;
                    m_err  <= 1'b0;
                    if (bus.op != OP_NOP) begin
                        m_acc   <= WIDTH'(f_raw(bus.op, m_acc, bus.operand) & MASK);
                        m_zero  <= (f_raw(bus.op, m_acc, bus.operand) & MASK) == 0;
                        m_carry <= f_carry(bus.op, m_acc, bus.operand, m_carry);
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (m_live) begin
                check("model_acc",      bus.acc,      m_acc);
                check("model_carry",    bus.carry,    m_carry);
                check("model_zero",     bus.zero,     m_zero);
                check("model_done",     bus.done,     m_done);
                check("model_busy",     bus.busy,     m_left > 0);
                check("model_in_ready", bus.in_ready, m_left == 0);
                if (m_done) check("model_err", bus.err, m_err);
            end
        end
    end

    task automatic send(input op_t o, input logic [WIDTH-1:0] v);
        bus.in_valid = 1'b1;
        bus.op       = o;
        bus.operand  = v;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        bus.op       = OP_NOP;
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (bus.done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    int lat;

    initial begin
        RESET = 1'b1;
        bus.in_valid = 1'b0;
        bus.op       = OP_NOP;
        bus.operand  = '0;
        repeat (2) @(negedge clk);
        check("rst_acc",  bus.acc,  8'h00);
        check("rst_zero", bus.zero, 1'b1);
        check("rst_carry", bus.carry, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        RESET = 1'b0;
        @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1'b1);

        send(OP_LOAD, 8'h0F);
        check("load_acc", bus.acc, 8'h0F);
        send(OP_ADD, 8'hF3);
        check("add_acc",   bus.acc,   8'h02);
        check("add_carry", bus.carry, 1'b1);
        check("add_zero",  bus.zero,  1'b0);
        check("add_done",  bus.done,  1'b1);
        idle(1);
        check("done_drop", bus.done, 1'b0);

        send(OP_LOAD, 8'h05);
        send(OP_SUB,  8'h07);
        check("sub_acc",    bus.acc,   8'hFE);
        check("sub_borrow", bus.carry, 1'b1);
        send(OP_SUB,  8'hFE);
        check("sub0_acc",   bus.acc,   8'h00);
        check("sub0_zero",  bus.zero,  1'b1);
        check("sub0_carry", bus.carry, 1'b0);

        send(OP_LOAD, 8'hFF);
        send(OP_ADD,  8'h01);
        check("wrap_acc",   bus.acc,   8'h00);
        check("wrap_carry", bus.carry, 1'b1);
        check("wrap_zero",  bus.zero,  1'b1);
        send(OP_NOP,  8'h5A);
        check("nop_acc",   bus.acc,   8'h00);
        check("nop_carry", bus.carry, 1'b1);
        check("nop_done",  bus.done,  1'b1);
        idle(1);

        send(OP_LOAD, 8'hAA);
        check("stream_load", bus.acc, 8'hAA);
        send(OP_XNOR, 8'h0F);
        check("stream_xnor", bus.acc, 8'h5A);
        check("stream_xnor_carry", bus.carry, 1'b0);
        send(OP_AND,  8'h5F);
        check("stream_and",  bus.acc, 8'h5A);
        send(OP_CLR,  8'h00);
        check("stream_clr",  bus.acc,  8'h00);
        check("stream_zero", bus.zero, 1'b1);
        check("stream_done", bus.done, 1'b1);
        idle(1);

`ifdef ACCUM_ALU_MUL_EN
        send(OP_LOAD, 8'h0C);
        send(OP_MUL,  8'h0B);
        idle(0);
        check("mul_busy",     bus.busy,     1'b1);
        check("mul_in_ready", bus.in_ready, 1'b0);
        check("mul_hold_acc", bus.acc,      8'h0C);
        wait_done(lat);
        check("mul_latency", lat, 8);
        check("mul_acc",   bus.acc,   8'h84);
        check("mul_carry", bus.carry, 1'b0);
        send(OP_MUL, 8'h10);
        idle(0);
        wait_done(lat);
        check("mul2_latency", lat, 8);
        check("mul2_acc",   bus.acc,   8'h40);
        check("mul2_carry", bus.carry, 1'b1);
        idle(1);

        send(OP_LOAD, 8'h21);
        send(OP_MUL,  8'h03);
        bus.in_valid = 1'b1;
        bus.op       = OP_LOAD;
        bus.operand  = 8'h77;
        repeat (3) @(negedge clk);
        check("busy_ignore_acc", bus.acc, 8'h21);
        RESET = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("abort_acc",  bus.acc,  8'h00);
        check("abort_zero", bus.zero, 1'b1);
        check("abort_done", bus.done, 1'b0);
        check("abort_busy", bus.busy, 1'b0);
        RESET = 1'b0;
        @(negedge clk);
        check("abort_in_ready", bus.in_ready, 1'b1);
        idle(12);
`else
        send(OP_LOAD, 8'h33);
        send(OP_MUL,  8'h02);
        check("illegal_acc",  bus.acc,  8'h33);
        check("illegal_err",  bus.err,  1'b1);
        check("illegal_done", bus.done, 1'b1);
        check("illegal_busy", bus.busy, 1'b0);
        idle(1);
        check("illegal_busy_after", bus.busy, 1'b0);
        send(OP_LOAD, 8'h01);
        check("legal_err", bus.err, 1'b0);
        idle(2);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/accum_alu.md
ACCUM_ALU -- requirements
Module: accum_alu

Interface
REQ-001 Parameter WIDTH, default 8, accumulator/operand width in bits (legal range 4..32).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 RESET  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  command present on op/operand.
REQ-005 in_ready  output  1  block accepts a command this cycle.
REQ-006 op  input  3  opcode: 000 NOP, 001 LOAD, 010 ADD, 011 SUB, 100 XNOR, 101 AND, 110 MUL, 111 CLR.
REQ-007 operand  input  WIDTH  second operand; the first operand is always the accumulator.
REQ-008 acc  output  WIDTH  registered accumulator value.
REQ-009 done  output  1  one-cycle pulse: command retired, acc and flags valid.
REQ-010 busy  output  1  multi-cycle operation in progress.
REQ-011 carry  output  1  ADD carry-out / SUB borrow / MUL overflow.
REQ-012 zero  output  1  last written acc equals 0.
REQ-013 err  output  1  last retired command was illegal; valid with done.

Function
REQ-014 Handshake: a command is accepted on a rising edge where in_valid && in_ready; in_ready SHALL equal (state == IDLE) and not depend on in_valid.
REQ-015 FSM states: IDLE, MUL; IDLE->MUL on accepted MUL; MUL->IDLE after the last iteration; every other accepted opcode stays in IDLE.
REQ-016 Single-cycle ops (LOAD, ADD, SUB, XNOR, AND, CLR, NOP) SHALL update acc on the accepting edge; done high for the following cycle only.
REQ-017 LOAD: acc=operand; ADD: acc=(acc+operand) mod 2^WIDTH, carry=bit WIDTH of the sum; SUB: acc=(acc-operand) mod 2^WIDTH, carry=1 iff operand>acc (unsigned).
REQ-018 XNOR: acc=~(acc^operand); AND: acc=acc&operand; CLR: acc=0; these three SHALL clear carry.
REQ-019 NOP: acc, carry, zero unchanged; done still pulses.
REQ-020 zero SHALL be recomputed from the new acc on every op that writes acc.
REQ-021 MUL: unsigned shift-add, one partial product per cycle, WIDTH iterations; acc=low WIDTH bits of acc*operand written on the WIDTH-th edge after acceptance; done high the cycle after; carry=1 iff high WIDTH bits of the product are nonzero.
REQ-022 busy high exactly while state==MUL; acc SHALL hold its pre-MUL value until the final write.
REQ-023 in_valid while busy SHALL be ignored (not accepted, not queued).
REQ-024 Back-to-back single-cycle commands SHALL be accepted every cycle with no bubble; done may stay high continuously.
REQ-025 err SHALL be 0 for every legal command.

Reset
REQ-026 RESET high at a rising edge SHALL force acc=0, carry=0, zero=1, err=0, done=0, busy=0, state=IDLE, iteration counter=0.
REQ-027 RESET SHALL override a simultaneous accepted command and SHALL abort an in-progress MUL with no done pulse.
REQ-028 in_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-029 Macro ACCUM_ALU_MUL_EN defined: MUL behaves per REQ-021.
REQ-030 Macro undefined: no multiplier logic; MUL is a single-cycle illegal op: acc/carry/zero unchanged, err=1, done pulses, busy never asserts.

Structure
REQ-031 Package accum_alu_pkg SHALL hold the opcode enum, the FSM state enum and the default WIDTH constant.
REQ-032 Sub-module accum_alu_mul SHALL implement the shift-add engine (start, multiplicand, multiplier, counter, product, last); instantiated only under ACCUM_ALU_MUL_EN.

Verification (WIDTH=8)
REQ-033 Reset, then LOAD 0x0F, ADD 0xF3 -> acc=0x02, carry=1, zero=0, one done per command.
REQ-034 LOAD 0x05, SUB 0x07 -> acc=0xFE, carry=1; SUB 0xFE -> acc=0x00, zero=1, carry=0.
REQ-035 MUL_EN: LOAD 0x0C, MUL 0x0B -> busy 8 cycles, in_ready low, acc=0x84 8 edges after acceptance, carry=0; MUL 0x10 next -> acc=0x40, carry=1.
REQ-036 MUL_EN: RESET asserted in 4th MUL cycle -> acc=0, zero=1, no done, in_ready=1 next cycle; in_valid during busy has no effect.
REQ-037 MUL_EN undefined: LOAD 0x33, MUL 0x02 -> acc=0x33, err=1 with done, busy never high.
REQ-038 Stream LOAD 0xAA, XNOR 0x0F, AND 0x5F, CLR on consecutive cycles -> acc 0xAA, 0x5A, 0x5A, 0x00; done high four cycles; zero=1 at end.
